// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_t;

endpackage

// File: rtl/hilo_muldiv_ctrl_sign_fix.sv
// Conditional two's-complement negate; serves as abs() on operands and as
// sign fixup on unit results.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // abs(0x80000000) wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register file and sequencer for MIPS-style mult/div using external
// unsigned multiplier and divider units.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_c,
  output logic        div_valid,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [63:0] div_c
);

  md_state_t  state;
  muldiv_op_t op;
  logic [31:0] op_a, op_b, a_mag, b_mag, quot, rem;
  logic [63:0] prod;
  logic        neg_res, neg_rem, killed;
  logic        signed_op, accept, drop;

  assign op        = muldiv_op_t'(in_op);
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign accept    = in_valid && !flush && (state == S_IDLE) && (op != MD_NONE);
  // A flush arriving on the completion cycle kills the result as well.
  assign drop      = killed || flush;

  muldiv_sign_fix #(.W(32)) u_abs_a (.val(in_a), .neg(signed_op && in_a[31]), .res(a_mag));
  muldiv_sign_fix #(.W(32)) u_abs_b (.val(in_b), .neg(signed_op && in_b[31]), .res(b_mag));
  muldiv_sign_fix #(.W(64)) u_fix_p (.val(mul_c), .neg(neg_res), .res(prod));
  muldiv_sign_fix #(.W(32)) u_fix_q (.val(div_c[31:0]), .neg(neg_res), .res(quot));
  muldiv_sign_fix #(.W(32)) u_fix_r (.val(div_c[63:32]), .neg(neg_rem), .res(rem));

  assign stall     = in_valid && (op != MD_NONE) && (state != S_IDLE);
  assign mul_valid = (state == S_MUL);
  assign div_valid = (state == S_DIV);
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign div_a     = op_a;
  assign div_b     = op_b;

  always_comb begin
    mf_data = '0;
    if (in_valid && op == MD_MFHI)      mf_data = hi;
    else if (in_valid && op == MD_MFLO) mf_data = lo;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      hi      <= '0;
      lo      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      killed  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          case (op)
            MD_MTHI: hi <= in_a;
            MD_MTLO: lo <= in_a;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              // Divide by zero is architecturally undefined; leave HI/LO alone.
              if (!((op == MD_DIV || op == MD_DIVU) && in_b == '0)) begin
                op_a    <= a_mag;
                op_b    <= b_mag;
                neg_res <= signed_op && (in_a[31] ^ in_b[31]);
                neg_rem <= signed_op && in_a[31];
                state   <= (op == MD_MULT || op == MD_MULTU) ? S_MUL : S_DIV;
              end
            end
            default: ;
          endcase
        end
        S_MUL: begin
          if (flush) killed <= 1'b1;
          if (mul_done) begin
            if (!drop) {hi, lo} <= prod;
            killed <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_DIV: begin
          if (flush) killed <= 1'b1;
          if (div_done) begin
            if (!drop) begin
              lo <= quot;
              hi <= rem;
            end
            killed <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench: stimulus pushes expected HI/LO and completion cycle,
// a monitor checks them on every unit completion handshake.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 3;

  logic        clk = 0, resetn = 0;
  logic        in_valid = 0, flush = 0;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_a = 0, in_b = 0;
  logic        stall, mul_valid, div_valid, mul_done, div_done;
  logic [31:0] mf_data, hi, lo, mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_c, div_c;
  logic        spur_mul = 0, spur_div = 0;
  int          mcnt = 0, dcnt = 0, cyc = 0;
  int          total = 0, bad = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  hilo_muldiv_ctrl dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .stall(stall), .mf_data(mf_data),
    .hi(hi), .lo(lo), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_c(mul_c), .div_valid(div_valid), .div_a(div_a),
    .div_b(div_b), .div_done(div_done), .div_c(div_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Fixed-latency unsigned unit models; they share the controller's reset.
  always @(posedge clk) begin
    if (!resetn || !mul_valid || mul_done) mcnt <= 0; else mcnt <= mcnt + 1;
    if (!resetn || !div_valid || div_done) dcnt <= 0; else dcnt <= dcnt + 1;
  end
  assign mul_done = (mul_valid && mcnt == MUL_LAT - 1) || spur_mul;
  assign div_done = (div_valid && dcnt == DIV_LAT - 1) || spur_div;
  assign mul_c    = {32'b0, mul_a} * {32'b0, mul_b};
  assign div_c    = (div_b == 0) ? 64'd0 : {div_a % div_b, div_a / div_b};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int c;
    if (resetn && ((mul_valid && mul_done) || (div_valid && div_done))) begin
      exp_t e;
      c = cyc;
      #1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: completion at cycle %0d with nothing expected", c);
      end else begin
        e = sb.pop_front();
        chk("done_hi", hi, e.hi);
        chk("done_lo", lo, e.lo);
        chk("done_cycle", c, e.cyc);
      end
    end
  end

  // Present an op until the controller takes it; returns the issue cycle.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output int ic);
    int n = 0;
    in_valid = 1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    while (stall && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL issue_timeout: stall=%b expected 0", stall); end
    ic = cyc;
    @(posedge clk); #1;
    in_valid = 0; in_op = MD_NONE;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #2;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL wait_timeout: pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic run(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    int ic;
    issue(op, a, b, ic);
    sb.push_back('{hi: ehi, lo: elo, cyc: ic + lat});
    wait_sb();
  endtask

  initial begin
    int ic, n;
    logic [31:0] h0, l0;
    resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_mf_data", mf_data, 0);
    @(posedge clk); #1 resetn = 1;

    issue(MD_MTHI, 32'h11111111, 0, ic);
    issue(MD_MTLO, 32'h22222222, 0, ic);
    chk("mthi", hi, 32'h11111111);
    chk("mtlo", lo, 32'h22222222);
    in_valid = 1; in_op = MD_MFHI; #1 chk("mfhi", mf_data, 32'h11111111);
    in_op = MD_MFLO; #1 chk("mflo", mf_data, 32'h22222222);
    in_op = MD_NONE; #1 chk("mf_none", mf_data, 0);
    in_valid = 0;

    run(MD_MULT,  32'hFFFFFFFE, 32'd3, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
    run(MD_MULT,  32'h80000000, 32'd2, MUL_LAT, 32'hFFFFFFFF, 32'h00000000);
    run(MD_DIV,   32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run(MD_DIVU,  32'd7, 32'd2, DIV_LAT, 32'd1, 32'd3);
    run(MD_DIV,   32'd7, 32'hFFFFFFFE, DIV_LAT, 32'd1, 32'hFFFFFFFD);

    // Divide by zero: nothing starts, nothing stalls, HI/LO untouched.
    in_valid = 1; in_op = MD_DIV; in_a = 32'd5; in_b = 0;
    @(negedge clk);
    chk("div0_stall", stall, 0);
    @(posedge clk); #1 in_valid = 0; in_op = MD_NONE;
    @(negedge clk);
    chk("div0_div_valid", div_valid, 0);
    chk("div0_hi", hi, 32'd1);
    chk("div0_lo", lo, 32'hFFFFFFFD);

    // Spurious completion pulses while idle are ignored.
    spur_mul = 1; spur_div = 1;
    @(posedge clk); #1 spur_mul = 0; spur_div = 0;
    chk("spur_hi", hi, 32'd1);
    chk("spur_lo", lo, 32'hFFFFFFFD);

    // MFHI right behind a DIV stalls through the completion cycle.
    issue(MD_DIV, 32'd100, 32'd7, ic);
    sb.push_back('{hi: 32'd2, lo: 32'd14, cyc: ic + DIV_LAT});
    in_valid = 1; in_op = MD_MFHI; n = 0;
    @(negedge clk);
    while (stall && n < 50) begin n++; @(negedge clk); end
    chk("mfhi_stall_cycles", n, DIV_LAT);
    chk("mfhi_after_div", mf_data, 32'd2);
    @(posedge clk); #1 in_valid = 0; in_op = MD_NONE;
    wait_sb();

    // Flush in IDLE discards an MTHI.
    in_valid = 1; in_op = MD_MTHI; in_a = 32'hDEADBEEF; flush = 1;
    @(posedge clk); #1 in_valid = 0; in_op = MD_NONE; flush = 0;
    chk("flush_idle_hi", hi, 32'd2);

    // Flush during DIV: unit drains, stall holds, result dropped.
    issue(MD_DIV, 32'd9, 32'd2, ic);
    sb.push_back('{hi: 32'd2, lo: 32'd14, cyc: ic + DIV_LAT});
    in_valid = 1; in_op = MD_MFLO; flush = 1;
    @(negedge clk);
    chk("flush_div_stall", stall, 1);
    @(posedge clk); #1 flush = 0; n = 1;
    @(negedge clk);
    while (stall && n < 50) begin n++; @(negedge clk); end
    chk("flush_stall_cycles", n, DIV_LAT);
    chk("flush_mflo", mf_data, 32'd14);
    @(posedge clk); #1 in_valid = 0; in_op = MD_NONE;
    wait_sb();

    // Reset mid-DIV abandons the op and clears HI/LO.
    issue(MD_DIV, 32'd50, 32'd3, ic);
    resetn = 0;
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_div_valid", div_valid, 0);
    repeat (4) @(posedge clk);
    #1 chk("midrst_hold_lo", lo, 0);

    run(MD_MULTU, 32'd3, 32'd5, MUL_LAT, 32'd0, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim still running, expected finish");
    $fatal(1);
  end

endmodule
